// File: rtl/en_tick_gen_pkg.sv
// Shared state encoding and default widths for the enable-pulse generator.
package en_tick_gen_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam int DIV_W_DEF   = 8;
    localparam int BURST_W_DEF = 8;

    typedef enum logic {
        IDLE = ST_IDLE,
        RUN  = ST_RUN
    } state_t;

endpackage

// File: rtl/en_tick_gen_if.sv
// Control/status bundle between the upstream controller (master) and en_tick_gen (slave).
interface en_tick_gen_if
    import en_tick_gen_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int BURST_W = BURST_W_DEF
);
    logic               start;
    logic               stop;
    logic [DIV_W-1:0]   div;
    logic [BURST_W-1:0] burst_len;
    logic               en;
    logic               busy;
    logic               done;
    logic [BURST_W-1:0] tick_count;

    modport master (
        output start, stop, div, burst_len,
        input  en, busy, done, tick_count
    );

    modport slave (
        input  start, stop, div, burst_len,
        output en, busy, done, tick_count
    );
endinterface

// File: rtl/en_tick_gen_tick_prescaler.sv
// Reloadable down-counter; tc flags terminal count while the run gate is open.
module tick_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             run,
    output logic             tc
);
    logic [DIV_W-1:0] cnt;

    assign tc = (cnt == '0) && run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/en_tick_gen.sv
// Programmable enable-pulse generator: one en pulse every div+1 cycles while running.
// Bounded bursts with a done pulse are built in only when EN_TICK_GEN_BURST_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for start; outputs quiet, tick_count holds last run's value
//   RUN   | prescaler counting down, en pulses on each terminal count
module en_tick_gen
    import en_tick_gen_pkg::*;
#(
    parameter int DIV_W   = DIV_W_DEF,
    parameter int BURST_W = BURST_W_DEF
) (
    input logic         clk,
    input logic         rst,
    en_tick_gen_if.slave bus
);
    state_t             state, state_n;
    logic [DIV_W-1:0]   div_q, div_n;
    logic [BURST_W-1:0] tick_q, tick_n;
    logic               en_q, en_n;
    logic               busy_q, busy_n;
    logic               done_q, done_n;
    logic               load, run, tc;
    logic [DIV_W-1:0]   load_val;
`ifdef EN_TICK_GEN_BURST_EN
    logic [BURST_W-1:0] len_q, len_n;
`endif

    // Gate kept outside the FSM block so tc never loops back through it.
    assign run = (state == RUN) && !bus.stop;

    tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .run      (run),
        .tc       (tc)
    );

    always_comb begin
        state_n  = state;
        div_n    = div_q;
        tick_n   = tick_q;
        en_n     = 1'b0;
        done_n   = 1'b0;
        load     = 1'b0;
        load_val = div_q;
`ifdef EN_TICK_GEN_BURST_EN
        len_n    = len_q;
`endif
        case (state)
            IDLE: begin
                if (bus.start && !bus.stop) begin
                    state_n  = RUN;
                    div_n    = bus.div;
                    tick_n   = '0;
                    load     = 1'b1;
                    load_val = bus.div;
`ifdef EN_TICK_GEN_BURST_EN
                    len_n    = bus.burst_len;
`endif
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_n = IDLE;
                end else if (tc) begin
                    en_n   = 1'b1;
                    load   = 1'b1;
                    tick_n = tick_q + 1'b1;
`ifdef EN_TICK_GEN_BURST_EN
                    if ((len_q != '0) && (tick_n == len_q)) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
`endif
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            div_q  <= '0;
            tick_q <= '0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef EN_TICK_GEN_BURST_EN
            len_q  <= '0;
`endif
        end else begin
            state  <= state_n;
            div_q  <= div_n;
            tick_q <= tick_n;
            en_q   <= en_n;
            busy_q <= busy_n;
            done_q <= done_n;
`ifdef EN_TICK_GEN_BURST_EN
            len_q  <= len_n;
`endif
        end
    end

    assign bus.en         = en_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.tick_count = tick_q;
endmodule

// File: tb/tb_en_tick_gen.sv
// Directed and randomized checks of en_tick_gen against an elapsed-cycle reference model.
module tb_en_tick_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    en_tick_gen_if #(.DIV_W(8), .BURST_W(8)) bus ();

    en_tick_gen #(.DIV_W(8), .BURST_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit burst_build;

    // Reference model: a run started at edge m_start ticks on every edge whose
    // distance from the start is a positive multiple of div+1.
    bit         m_run  = 1'b0;
    int         m_start = 0;
    int         m_d    = 0;
    int         m_len  = 0;
    logic [7:0] m_tc   = '0;
    logic       m_en   = 1'b0;
    logic       m_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_run = 1'b0; m_tc = '0; m_en = 1'b0; m_done = 1'b0;
        end else if (m_run) begin
            m_en = 1'b0; m_done = 1'b0;
            if (bus.stop) begin
                m_run = 1'b0;
            end else if (((cyc - m_start) % (m_d + 1)) == 0) begin
                m_en = 1'b1;
                m_tc = m_tc + 8'd1;
                if (burst_build && (m_len != 0) && (int'(m_tc) == m_len)) begin
                    m_done = 1'b1;
                    m_run  = 1'b0;
                end
            end
        end else begin
            m_en = 1'b0; m_done = 1'b0;
            if (bus.start && !bus.stop) begin
                m_run = 1'b1; m_start = cyc; m_d = int'(bus.div);
                m_len = int'(bus.burst_len); m_tc = '0;
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        check({tag, ".en"},   32'(bus.en),         32'(m_en));
        check({tag, ".busy"}, 32'(bus.busy),       32'(m_run));
        check({tag, ".done"}, 32'(bus.done),       32'(m_done));
        check({tag, ".tc"},   32'(bus.tick_count), 32'(m_tc));
    endtask

    initial begin
        int n_en, n_done;
`ifdef EN_TICK_GEN_BURST_EN
        burst_build = 1'b1;
`else
        burst_build = 1'b0;
`endif
        bus.start = 1'b0; bus.stop = 1'b0; bus.div = '0; bus.burst_len = '0;

        // 1: reset, then quiet
        step("t1_rst"); step("t1_rst");
        rst = 1'b0;
        n_en = 0;
        for (int k = 0; k < 20; k++) begin
            step("t1_idle");
            if (bus.en) n_en++;
        end
        check("t1_no_en", 32'(n_en), 32'd0);

        // 2: div=3 unbounded
        bus.div = 8'd3; bus.burst_len = 8'd0; bus.start = 1'b1;
        step("t2_start");
        bus.start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step("t2_run");
            check("t2_en_phase", 32'(bus.en), 32'((k % 4) == 0));
            check("t2_busy", 32'(bus.busy), 32'd1);
        end
        check("t2_count", 32'(bus.tick_count), 32'd3);
        bus.stop = 1'b1; step("t2_stop"); bus.stop = 1'b0;

        // 3: div=0 for 300 cycles, tick_count wraps
        bus.div = 8'd0; bus.start = 1'b1;
        step("t3_start");
        bus.start = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            step("t3_run");
            check("t3_en", 32'(bus.en), 32'd1);
            if (k == 255) check("t3_top", 32'(bus.tick_count), 32'd255);
            if (k == 256) check("t3_wrap", 32'(bus.tick_count), 32'd0);
        end
        check("t3_busy", 32'(bus.busy), 32'd1);
        bus.stop = 1'b1; step("t3_stop"); bus.stop = 1'b0;

        // 4: stop on the tick edge, then start+stop together
        bus.div = 8'd2; bus.start = 1'b1;
        step("t4_start");
        bus.start = 1'b0;
        step("t4_run"); step("t4_run");
        bus.stop = 1'b1;
        step("t4_stop");
        check("t4_stop_en", 32'(bus.en), 32'd0);
        check("t4_stop_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        step("t4_both");
        check("t4_both_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b0; bus.stop = 1'b0;
        step("t4_idle");

        // 5: burst of 4 with div=1
        bus.div = 8'd1; bus.burst_len = 8'd4; bus.start = 1'b1;
        step("t5_start");
        bus.start = 1'b0;
        n_en = 0; n_done = 0;
        for (int k = 1; k <= 10; k++) begin
            step("t5_run");
            if (bus.en) n_en++;
            if (bus.done) n_done++;
            if (k == 8) check("t5_done8", 32'(bus.done), 32'(burst_build));
        end
        check("t5_pulses", 32'(n_en), burst_build ? 32'd4 : 32'd5);
        check("t5_ndone", 32'(n_done), burst_build ? 32'd1 : 32'd0);
        check("t5_busy_end", 32'(bus.busy), burst_build ? 32'd0 : 32'd1);
        bus.stop = 1'b1; bus.burst_len = 8'd0; step("t5_stop"); bus.stop = 1'b0;

        // 6: asynchronous reset mid-run
        bus.div = 8'd1; bus.start = 1'b1;
        step("t6_start");
        bus.start = 1'b0;
        for (int k = 0; k < 5; k++) step("t6_run");
        #2 rst = 1'b1;
        #1;
        check("t6_async_en", 32'(bus.en), 32'd0);
        check("t6_async_busy", 32'(bus.busy), 32'd0);
        check("t6_async_tc", 32'(bus.tick_count), 32'd0);
        step("t6_rst");
        rst = 1'b0;
        bus.div = 8'd1; bus.start = 1'b1;
        step("t6_restart");
        bus.start = 1'b0;
        step("t6_e1");
        check("t6_first_en_1", 32'(bus.en), 32'd0);
        step("t6_e2");
        check("t6_first_en_2", 32'(bus.en), 32'd1);

        // randomized run/stop traffic, including mid-run config changes
        for (int i = 0; i < 800; i++) begin
            bus.start     = (!m_run && ($urandom % 4 == 0)) || ($urandom % 16 == 0);
            bus.stop      = ($urandom % 25 == 0);
            bus.div       = 8'($urandom_range(0, 5));
            bus.burst_len = 8'($urandom_range(0, 6));
            step("rnd");
        end

        bus.start = 1'b0; bus.stop = 1'b1;
        step("end");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
